uart_tx_fifo: RTL

Byte-oriented UART transmitter (8N1, LSB first) with a small input FIFO and valid/ready handshake, running in the 20 MHz domain. It is the transmit-side counterpart of the GPU's `rx` serial input. On the FPGA it drives scene/command bytes into `rx` for bring-up and loopback tests, and it returns debug bytes to the host. Upstream logic pushes bytes; the block serializes them at a fixed baud rate, back-to-back, with no idle gap while data is queued.

---
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter fed by a small circular FIFO.
// Bytes enter through a valid/ready handshake and are serialized back-to-back
// at CLKS_PER_BIT clocks per bit. The serial line is driven from a flop.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 174,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_20,
    input  logic                          reset,
    input  logic [7:0]                    tx_data_in,
    input  logic                          tx_data_valid_in,
    output logic                          tx_ready_out,
    output logic                          tx,
    output logic                          tx_busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state;
    state_t              state_next;
    logic [BAUD_W-1:0]   baud_cnt;
    logic                baud_done;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push;
    logic                pop;
    logic                tx_next;

    assign baud_done      = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx_ready_out   = (count < CNT_W'(FIFO_DEPTH));
    assign push           = tx_data_valid_in && tx_ready_out;
    assign fifo_count_out = count;
    assign tx_busy_out    = (state != IDLE) || (count != '0);

    // State register.
    always_ff @(posedge clk_20) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode, FIFO pop request and next serial bit level.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) state_next = DATA;
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_done && (bit_idx == 3'd7)) state_next = STOP;
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud and bit-index counters; a pop restarts the baud timer for the start bit.
    always_ff @(posedge clk_20) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
        end else begin
            if (pop)                   baud_cnt <= '0;
            else if (state != IDLE)    baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
            if (state == START && baud_done)     bit_idx <= 3'd0;
            else if (state == DATA && baud_done) bit_idx <= bit_idx + 3'd1;
        end
    end

    // Shift register: loaded on pop, shifted right at the end of each data bit.
    always_ff @(posedge clk_20) begin
        if (pop)                             shift <= mem[rd_ptr];
        else if (state == DATA && baud_done) shift <= shift >> 1;
    end

    // FIFO storage write port.
    always_ff @(posedge clk_20) begin
        if (push) mem[wr_ptr] <= tx_data_in;
    end

    // FIFO pointers and occupancy count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_20) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered serial output so the line never glitches.
    always_ff @(posedge clk_20) begin
        if (reset) tx <= 1'b1;
        else       tx <= tx_next;
    end

endmodule
